// File: rtl/brief_pkg.sv
// Shared types and defaults for the BRIEF line controller: FSM state encoding,
// counter width and default frame/patch geometry.
package brief_pkg;

  localparam int CNT_W      = 11;
  localparam int DEF_LINE_W = 1080;
  localparam int DEF_LINES  = 720;
  localparam int DEF_WIN    = 31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  // Padding needed to push the bottom half-window of the last line through.
  function automatic int flush_len(input int win, input int line_w);
    return ((win - 1) / 2) * line_w;
  endfunction

endpackage

// File: rtl/brief_line_ctrl_if.sv
// Pixel-stream control bundle between the frame source (master) and the
// line controller (slave).
interface brief_line_ctrl_if;
  import brief_pkg::*;

  logic             i_sof;
  logic             i_valid;
  logic             o_shift_en;
  logic             o_flush;
  logic [CNT_W-1:0] o_col;
  logic [CNT_W-1:0] o_row;
  logic             o_win_valid;
  logic             o_eol;
  logic             o_eof;
  logic             o_busy;
  logic             o_err;

  modport master (
    output i_sof, i_valid,
    input  o_shift_en, o_flush, o_col, o_row, o_win_valid,
           o_eol, o_eof, o_busy, o_err
  );

  modport slave (
    input  i_sof, i_valid,
    output o_shift_en, o_flush, o_col, o_row, o_win_valid,
           o_eol, o_eof, o_busy, o_err
  );

endinterface

// File: rtl/brief_pos_cnt.sv
// Column/row position counter pair: advances on accepted pixels, wraps at the
// line and frame boundaries and emits a registered end-of-line pulse.
module brief_pos_cnt
  import brief_pkg::*;
#(
  parameter int P_LINE_W = DEF_LINE_W,
  parameter int P_LINES  = DEF_LINES
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_adv,
  output logic [CNT_W-1:0] o_col,
  output logic [CNT_W-1:0] o_row,
  output logic             o_line_end,
  output logic             o_frame_end,
  output logic             o_eol
);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(P_LINE_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(P_LINES - 1);

  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             eol_q;
  logic             line_end, frame_end;

  assign line_end  = i_adv && (col_q == COL_LAST);
  assign frame_end = line_end && (row_q == ROW_LAST);

  always_comb begin
    // NOTE: defaults first so every path assigns the next state and no latch is inferred.
    col_d = col_q;
    row_d = row_q;
    if (i_clr) begin
      col_d = '0;
      row_d = '0;
    end else if (line_end) begin
      col_d = '0;
      row_d = frame_end ? '0 : row_q + 1'b1;
    end else if (i_adv) begin
      col_d = col_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (i_rst) begin
      col_q <= '0;
      row_q <= '0;
      eol_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      eol_q <= line_end && !i_clr;
    end
  end

  assign o_col       = col_q;
  assign o_row       = row_q;
  assign o_line_end  = line_end;
  assign o_frame_end = frame_end;
  assign o_eol       = eol_q;

endmodule

// File: rtl/brief_line_ctrl.sv
// Line controller feeding a P_WIN-tall shift-line chain for BRIEF patches.
// Macro BRIEF_LINE_CTRL_FLUSH_EN adds the end-of-frame zero-padding FLUSH state.
module brief_line_ctrl
  import brief_pkg::*;
#(
  parameter int P_LINE_W = DEF_LINE_W,
  parameter int P_LINES  = DEF_LINES,
  parameter int P_WIN    = DEF_WIN
) (
  input logic               i_clk,
  input logic               i_rst,
  brief_line_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] WIN_LAST   = CNT_W'(P_WIN - 1);
  localparam logic [CNT_W-1:0] ROW_TO_RUN = CNT_W'(P_WIN - 2);

  state_e           state_q;
  logic             win_q, eof_q, err_q;
  logic             in_line, accept;
  logic [CNT_W-1:0] col, row;
  logic             line_end, frame_end, eol;

  assign in_line = (state_q == ST_FILL) || (state_q == ST_RUN);
  // A start-of-frame restarts the counters, so the pixel beside it is not counted.
  assign accept  = in_line && bus.i_valid && !bus.i_sof;

  brief_pos_cnt #(
    .P_LINE_W (P_LINE_W),
    .P_LINES  (P_LINES)
  ) u_pos_cnt (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clr       (bus.i_sof),
    .i_adv       (accept),
    .o_col       (col),
    .o_row       (row),
    .o_line_end  (line_end),
    .o_frame_end (frame_end),
    .o_eol       (eol)
  );

`ifdef BRIEF_LINE_CTRL_FLUSH_EN
  localparam int               FLUSH_LEN  = flush_len(P_WIN, P_LINE_W);
  localparam int               FLUSH_W    = $clog2(FLUSH_LEN + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);

  logic [FLUSH_W-1:0] fcnt_q;

  assign bus.o_flush = (state_q == ST_FLUSH);
`else
  assign bus.o_flush = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      win_q   <= 1'b0;
      eof_q   <= 1'b0;
      err_q   <= 1'b0;
`ifdef BRIEF_LINE_CTRL_FLUSH_EN
      fcnt_q  <= '0;
`endif
    end else begin
      eof_q <= 1'b0;
      win_q <= accept && (row >= WIN_LAST) && (col >= WIN_LAST);
      case (state_q)
        ST_IDLE: begin
          if (bus.i_sof) state_q <= ST_FILL;
        end
        ST_FILL, ST_RUN: begin
          if (bus.i_sof) begin
            err_q   <= 1'b1;
            state_q <= ST_FILL;
          end else if (frame_end) begin
`ifdef BRIEF_LINE_CTRL_FLUSH_EN
            state_q <= ST_FLUSH;
            fcnt_q  <= '0;
`else
            state_q <= ST_IDLE;
            eof_q   <= 1'b1;
`endif
          end else if (state_q == ST_FILL && line_end && row == ROW_TO_RUN) begin
            state_q <= ST_RUN;
          end
        end
`ifdef BRIEF_LINE_CTRL_FLUSH_EN
        ST_FLUSH: begin
          if (bus.i_sof) begin
            err_q   <= 1'b1;
            state_q <= ST_FILL;
          end else if (fcnt_q == FLUSH_LAST) begin
            state_q <= ST_IDLE;
            eof_q   <= 1'b1;
          end else begin
            fcnt_q <= fcnt_q + 1'b1;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_shift_en  = (in_line && bus.i_valid) || bus.o_flush;
  assign bus.o_col       = col;
  assign bus.o_row       = row;
  assign bus.o_win_valid = win_q;
  assign bus.o_eol       = eol;
  assign bus.o_eof       = eof_q;
  assign bus.o_busy      = (state_q != ST_IDLE);
  assign bus.o_err       = err_q;

endmodule

// File: doc/brief_line_ctrl.md
BRIEF_LINE_CTRL -- requirements
Module: brief_line_ctrl

Interface
REQ-001 Parameter P_LINE_W, default 1080, is the pixels per line and equals the depth of the downstream shift line.
REQ-002 Parameter P_LINES, default 720, is the lines per frame.
REQ-003 Parameter P_WIN, default 31, is the BRIEF patch size; it SHALL be odd and at least 3.
REQ-004 i_clk  in  1  sole clock; all logic is rising-edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-high.
REQ-006 i_sof  in  1  start-of-frame pulse.
REQ-007 i_valid  in  1  pixel valid for the current cycle.
REQ-008 o_shift_en  out  1  enable to the shift-line chain.
REQ-009 o_flush  out  1  high while padding pixels are shifted; the upstream data mux selects 0.
REQ-010 o_col  out  11  column of the last shifted pixel, registered.
REQ-011 o_row  out  11  row of the last shifted pixel, registered.
REQ-012 o_win_valid  out  1  the full P_WIN x P_WIN window is resident.
REQ-013 o_eol  out  1  one-cycle end-of-line pulse.
REQ-014 o_eof  out  1  one-cycle end-of-frame pulse.
REQ-015 o_busy  out  1  the state machine is not in IDLE.
REQ-016 o_err  out  1  sticky protocol error flag.

Function
REQ-017 The states SHALL be IDLE, FILL, RUN and FLUSH.
REQ-018 In IDLE: o_shift_en=0 and i_valid is ignored; i_sof clears the column and row counters and moves the state to FILL.
REQ-019 In FILL and RUN: o_shift_en=i_valid, combinationally, with zero latency.
REQ-020 Each accepted pixel increments the column counter; at P_LINE_W-1 it wraps to 0, the row counter increments, and o_eol pulses on the next cycle.
REQ-021 When i_valid=0, both counters and all pulses hold.
REQ-022 FILL moves to RUN on the column wrap that makes row = P_WIN-1.
REQ-023 o_win_valid is registered, one cycle after an accepted pixel with row >= P_WIN-1 and col >= P_WIN-1; it is 0 otherwise and always 0 in FLUSH.
REQ-024 Acceptance of the pixel at row P_LINES-1, column P_LINE_W-1 ends the frame and moves to FLUSH, or to IDLE per REQ-032.
REQ-025 In FLUSH: o_shift_en=1 and o_flush=1 for exactly ((P_WIN-1)/2)*P_LINE_W cycles, counted by a flush counter; the state then returns to IDLE with o_eof pulsed on the IDLE-entry cycle.
REQ-026 If i_sof arrives in FILL, RUN or FLUSH: o_err is set, the counters clear, and the state is FILL; i_sof wins over a simultaneous last pixel (no o_eof).
REQ-027 o_err clears only on reset.
REQ-028 Counter arithmetic is unsigned, 11 bits; P_LINE_W and P_LINES SHALL be at most 2048.

Reset
REQ-029 On i_rst=1, asynchronously, the state SHALL be IDLE and every counter and output SHALL be 0, including o_err.
REQ-030 Reset mid-frame SHALL abandon the frame with no o_eof pulse.
REQ-031 After i_rst deasserts, the block SHALL wait for i_sof.

Configuration
REQ-032 Macro BRIEF_LINE_CTRL_FLUSH_EN:
- Defined: FLUSH exists and behaves per REQ-025.
- Undefined: FLUSH logic and its counter are absent; o_flush is tied to 0; the last pixel goes directly to IDLE with o_eof on the following cycle.

Structure
REQ-033 A shared package brief_pkg SHALL hold the state enum typedef, the counter width constant (11) and the default P_LINE_W, P_LINES and P_WIN.
REQ-034 One sub-module, brief_pos_cnt, SHALL hold the column/row counter pair with wrap and o_eol generation.

Verification
The bench uses P_LINE_W=8, P_LINES=6, P_WIN=3.
REQ-035 Reset applied mid-RUN -> all outputs are 0 in the same cycle, with no clock edge needed; o_busy=0.
REQ-036 i_sof, then 48 continuous valid pixels -> 48 o_shift_en cycles; 6 o_eol pulses; first o_win_valid one cycle after pixel 18 (row 2, col 2); 24 o_win_valid cycles total.
REQ-037 Same frame with i_valid toggling 1,0 -> counters hold on the 0 cycles; o_shift_en mirrors i_valid; o_win_valid count stays 24.
REQ-038 FLUSH_EN defined -> after the last pixel, 8 cycles with o_shift_en=o_flush=1, then o_eof for 1 cycle and o_busy=0. Undefined -> o_eof 1 cycle after the last pixel and o_flush always 0.
REQ-039 i_sof at row 3, col 4 -> o_err=1 (sticky); o_row=o_col=0; state FILL; the next 48 pixels complete normally with one o_eof.
